// File: rtl/conv_fprop1_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_fprop1_mul_pkg
// Purpose  : Shared constants and types for the conv_fprop1 multiplier arbiter.
// Revision : 1.0
// ============================================================================
package conv_fprop1_mul_pkg;

    localparam int NUM_REQ     = 4;
    localparam int ID_W        = 2;
    localparam int DIN_WIDTH   = 31;
    localparam int DOUT_WIDTH  = 62;
    localparam int MUL_LATENCY = 1;

    localparam int OPERAND_W   = DIN_WIDTH;
    localparam int PRODUCT_W   = DOUT_WIDTH;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } mul_stage_t;

endpackage : conv_fprop1_mul_pkg
`default_nettype wire

// File: rtl/conv_fprop1_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : conv_fprop1_rr_arb
// Purpose  : Round-robin grant with enable; pointer advances past each winner.
// Revision : 1.0
// ============================================================================
module conv_fprop1_rr_arb
    import conv_fprop1_mul_pkg::*;
#(
    parameter int NUM_REQ = conv_fprop1_mul_pkg::NUM_REQ,
    parameter int ID_W    = conv_fprop1_mul_pkg::ID_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] scan_idx;

    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        scan_idx    = '0;
        if (en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scan_idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
                if (!grant_valid && req[scan_idx]) begin
                    grant_valid     = 1'b1;
                    grant_id        = scan_idx;
                    grant[scan_idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : conv_fprop1_rr_arb
`default_nettype wire

// File: rtl/conv_fprop1_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : conv_fprop1_mul_arbiter
// Purpose  : Shares one pipelined multiplier core among NUM_REQ requesters.
// Revision : 1.0
// ============================================================================
module conv_fprop1_mul_arbiter
    import conv_fprop1_mul_pkg::*;
#(
    parameter int NUM_REQ     = conv_fprop1_mul_pkg::NUM_REQ,
    parameter int ID_W        = conv_fprop1_mul_pkg::ID_W,
    parameter int DIN_WIDTH   = conv_fprop1_mul_pkg::DIN_WIDTH,
    parameter int DOUT_WIDTH  = conv_fprop1_mul_pkg::DOUT_WIDTH,
    parameter int MUL_LATENCY = conv_fprop1_mul_pkg::MUL_LATENCY
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0] req_b,
    output logic                         mul_ce,
    output logic [DIN_WIDTH-1:0]         mul_din0,
    output logic [DIN_WIDTH-1:0]         mul_din1,
    input  logic [DOUT_WIDTH-1:0]        mul_dout,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [DOUT_WIDTH-1:0]        res_data,
    output logic [ID_W-1:0]              res_id,
    output logic                         busy
);

    logic [NUM_REQ-1:0]               grant;
    logic [ID_W-1:0]                  gnt_id;
    logic                             gnt_valid;

    logic [MUL_LATENCY-1:0]           v_q;
    logic [MUL_LATENCY-1:0]           v_d;
    logic [MUL_LATENCY-1:0][ID_W-1:0] t_q;
    logic [MUL_LATENCY-1:0][ID_W-1:0] t_d;

    // Stage valids are clear during reset, so the core keeps flushing then.
    assign mul_ce    = !(res_valid && !res_ready);
    assign res_valid = v_q[MUL_LATENCY-1];
    assign res_id    = t_q[MUL_LATENCY-1];
    assign res_data  = mul_dout;
    assign busy      = |v_q;
    assign req_ready = grant;

    conv_fprop1_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arb (
        .clk         (clk),
        .reset       (reset),
        .en          (mul_ce && reset),
        .req         (req_valid),
        .grant       (grant),
        .grant_id    (gnt_id),
        .grant_valid (gnt_valid)
    );

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        if (gnt_valid) begin
            mul_din0 = req_a[int'(gnt_id)*DIN_WIDTH +: DIN_WIDTH];
            mul_din1 = req_b[int'(gnt_id)*DIN_WIDTH +: DIN_WIDTH];
        end
    end

    always_comb begin
        v_d = v_q;
        t_d = t_q;
        if (mul_ce) begin
            v_d[0] = gnt_valid;
            t_d[0] = gnt_id;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                v_d[k] = v_q[k-1];
                t_d[k] = t_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= '0;
            t_q <= '0;
        end else begin
            v_q <= v_d;
            t_q <= t_d;
        end
    end

endmodule : conv_fprop1_mul_arbiter
`default_nettype wire

// File: tb/tb_conv_fprop1_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_fprop1_mul_arbiter
// Purpose  : Self-checking bench with a queue-based model of the arbiter.
// Revision : 1.0
// ============================================================================
module tb_conv_fprop1_mul_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DW = 31;
    localparam int OW = 62;
    localparam int L  = 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic            mul_ce;
    logic [DW-1:0]   mul_din0;
    logic [DW-1:0]   mul_din1;
    logic [OW-1:0]   mul_dout = '0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [OW-1:0]   res_data;
    logic [IW-1:0]   res_id;
    logic            busy;

    conv_fprop1_mul_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External multiplier core, one ce-qualified stage.
    always @(posedge clk) if (mul_ce) mul_dout <= OW'(mul_din0) * OW'(mul_din1);

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: every accepted product carries its count of ce edges since accept.
    typedef struct {
        int            age;
        int            id;
        logic [OW-1:0] prod;
    } item_t;

    item_t         items[$];
    int            m_ptr = 0;
    logic          m_ce;
    logic          m_acc;
    int            m_g;
    logic [OW-1:0] m_prod;
    logic          exp_rv;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    int            glog[$];
    logic [OW-1:0] last_id0 = '0;
    int            dut_res = 0;

    always @(negedge clk) begin
        if (!reset) begin
            items.delete();
            m_ptr = 0;
        end
        exp_rv  = reset && items.size() > 0 && items[0].age == L;
        m_ce    = !(exp_rv && !res_ready);
        m_acc   = 1'b0;
        m_g     = 0;
        exp_rdy = '0;
        ea      = '0;
        eb      = '0;
        if (reset && m_ce) begin
            for (int i = 0; i < N; i++) begin
                if (!m_acc && req_valid[(m_ptr + i) % N]) begin
                    m_acc = 1'b1;
                    m_g   = (m_ptr + i) % N;
                end
            end
        end
        if (m_acc) begin
            exp_rdy[m_g] = 1'b1;
            ea     = req_a[m_g*DW +: DW];
            eb     = req_b[m_g*DW +: DW];
            m_prod = OW'(ea) * OW'(eb);
            glog.push_back(m_g);
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("mul_ce", 64'(mul_ce), 64'(m_ce));
        chk("mul_din0", 64'(mul_din0), 64'(ea));
        chk("mul_din1", 64'(mul_din1), 64'(eb));
        chk("res_valid", 64'(res_valid), 64'(exp_rv));
        chk("busy", 64'(busy), 64'(items.size() > 0));
        if (exp_rv) begin
            chk("res_id", 64'(res_id), 64'(items[0].id));
            chk("res_data", 64'(res_data), 64'(items[0].prod));
            if (items[0].id == 0) last_id0 = res_data;
        end
        if (res_valid && res_ready) dut_res++;
    end

    always @(posedge clk) begin
        if (!reset) begin
            items.delete();
            m_ptr = 0;
        end else if (m_ce) begin
            foreach (items[k]) items[k].age++;
            if (items.size() > 0 && items[0].age > L) void'(items.pop_front());
            if (m_acc) begin
                items.push_back('{1, m_g, m_prod});
                m_ptr = (m_g + 1) % N;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic chk_glog(input string name, input int exp[4], input int cnt);
        chk({name, "_len"}, 64'(glog.size()), 64'(cnt));
        for (int i = 0; i < cnt; i++) begin
            chk(name, 64'((i < glog.size()) ? glog[i] : -1), 64'(exp[i % 4]));
        end
    endtask

    logic [OW-1:0] hold_data;
    logic [IW-1:0] hold_id;
    int            res_snap;

    initial begin
        // Reset with every requester asking
        reset     = 1'b0;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        step(3);
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ce", 64'(mul_ce), 64'(1));

        // First transaction
        reset     = 1'b1;
        req_valid = 4'b0001;
        set_req(0, 31'd3, 31'd5);
        #1;
        chk("first_ready", 64'(req_ready), 64'(4'b0001));
        step(1);
        req_valid = 4'b0000;
        chk("first_valid", 64'(res_valid), 64'(1));
        chk("first_data", 64'(res_data), 64'(15));
        chk("first_id", 64'(res_id), 64'(0));
        step(1);

        // Full load rotation; pointer sits at 1 after the first accept
        set_req(0, 31'h7FFF_FFFF, 31'h7FFF_FFFF);
        set_req(1, 31'd11, 31'd2);
        set_req(2, 31'd12, 31'd3);
        set_req(3, 31'd13, 31'd4);
        glog.delete();
        req_valid = 4'b1111;
        step(8);
        req_valid = 4'b0000;
        chk_glog("rot_grant", '{1, 2, 3, 0}, 8);
        step(2);
        chk("max_product", 64'(last_id0), 64'h3FFF_FFFF_0000_0001);

        // Backpressure with results in flight
        req_valid = 4'b1111;
        step(2);
        res_ready = 1'b0;
        #1;
        chk("bp_ce", 64'(mul_ce), 64'(0));
        chk("bp_ready", 64'(req_ready), 64'(0));
        hold_data = res_data;
        hold_id   = res_id;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_data_hold", 64'(res_data), 64'(hold_data));
            chk("bp_id_hold", 64'(res_id), 64'(hold_id));
        end
        req_valid = 4'b0000;
        res_ready = 1'b1;
        step(4);
        chk("bp_drained", 64'(busy), 64'(0));

        // Pointer wrap: leave pointer at 2, then req3/req1 alternate
        req_valid = 4'b0010;
        step(1);
        req_valid = 4'b1010;
        glog.delete();
        step(4);
        req_valid = 4'b0000;
        chk_glog("wrap_grant", '{3, 1, 3, 1}, 4);
        step(2);

        // Reset while products are in flight
        req_valid = 4'b1111;
        step(1);
        req_valid = 4'b0000;
        chk("mid_busy_before", 64'(busy), 64'(1));
        reset = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'(0));
        chk("mid_res_valid", 64'(res_valid), 64'(0));
        step(2);
        reset = 1'b1;
        res_snap = dut_res;
        step(4);
        chk("mid_no_stale", 64'(dut_res), 64'(res_snap));
        chk("mid_idle", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_conv_fprop1_mul_arbiter
`default_nettype wire
